// File: rtl/br_pkg.sv
// Shared definitions for the branch resolve unit: funct3 codes, BHT counter
// encodings, flush FSM states and the counter saturation helper.
package br_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic {IDLE, FLUSH} state_t;

  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    if (up) return (cnt == ST) ? ST : cnt + 2'd1;
    else    return (cnt == SNT) ? SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters; combinational read
// returns the pre-update counter MSB, updates land on the clock edge.
module bht_2bit #(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);
  import br_pkg::*;

  logic [1:0] cnt [2**IDX_W];

  assign rd_taken = cnt[rd_idx][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**IDX_W; i++) cnt[i] <= WNT;
    end else if (wr_en) begin
      cnt[wr_idx] <= sat_step(cnt[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves RV32I conditional branches at EX, trains the BHT, and on a
// misprediction issues a registered redirect followed by a timed flush.
//   state | meaning
//   IDLE  | resolving EX branches normally
//   FLUSH | wrong-path window; EX inputs ignored, flush held high
module branch_resolve_unit #(
  parameter int XLEN         = 32,
  parameter int BHT_IDX_W    = 6,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            illegal_br,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);
  import br_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state, state_nxt;
  logic [3:0] fcnt, fcnt_nxt;
  logic       res, legal, taken, upd, mispredict;

  logic unused_ok;
  assign unused_ok = ^{if_pc[XLEN-1:BHT_IDX_W+2], if_pc[1:0]};

  always_comb begin
    taken = 1'b0;
    case (ex_funct3)
      F3_BEQ:  taken = (ex_rs1 == ex_rs2);
      F3_BNE:  taken = (ex_rs1 != ex_rs2);
      F3_BLT:  taken = ($signed(ex_rs1) <  $signed(ex_rs2));
      F3_BGE:  taken = ($signed(ex_rs1) >= $signed(ex_rs2));
      F3_BLTU: taken = (ex_rs1 <  ex_rs2);
      F3_BGEU: taken = (ex_rs1 >= ex_rs2);
      default: taken = 1'b0;
    endcase
  end

  assign res        = ex_valid & ex_branch & (state == IDLE);
  assign legal      = ex_funct3[2] | ~ex_funct3[1];
  assign upd        = res & legal;
  assign mispredict = upd & (taken != ex_pred_taken);
  assign flush      = (state == FLUSH);

  bht_2bit #(.IDX_W(BHT_IDX_W)) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (if_pc[BHT_IDX_W+1:2]),
    .rd_taken (if_pred_taken),
    .wr_en    (upd),
    .wr_idx   (ex_pc[BHT_IDX_W+1:2]),
    .wr_taken (taken)
  );

  // Down-counter terminates at 1 so flush spans exactly FLUSH_CYCLES cycles.
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    case (state)
      IDLE: begin
        if (mispredict) begin
          state_nxt = FLUSH;
          fcnt_nxt  = 4'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        fcnt_nxt = fcnt - 4'd1;
        if (fcnt == 4'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect    <= 1'b0;
      redirect_pc <= '0;
      illegal_br  <= 1'b0;
      br_count    <= '0;
      mp_count    <= '0;
    end else begin
      redirect   <= mispredict;
      illegal_br <= res & ~legal;
      if (mispredict) redirect_pc <= taken ? ex_target : ex_pc + XLEN'(4);
      if (upd && br_count != CNT_MAX) br_count <= br_count + CNT_W'(1);
      if (mispredict && mp_count != CNT_MAX) mp_count <= mp_count + CNT_W'(1);
    end
  end

endmodule
